alu_share_arbiter: RTL and testbench
====================================

# alu_share_arbiter

Shares one `ALU` instance between two independent requesters, for example the execute stage and a branch/address helper. The arbiter holds each request to a valid/ready handshake and arbitrates round-robin between the two requesters. It drives the granted operands into the combinational `ALU` and returns the registered result, tagged with the requester ID, on a single response channel. It sits between the requesters and the `ALU`, and the `ALU` is its only compute resource.

## Interface
- `W`, 32: operand/result width; fixed at 32 to match `ALU`.
- `CNT_W`, 16: width of the conflict counter.

- `CLK`  in  1  clock; all state updates on the rising edge.
- `Reset`  in  1  synchronous, active-high reset.
- `req0_valid` / `req1_valid`  in  1  requester n presents an operation.
- `req0_ready` / `req1_ready`  out  1  requester n's operation is accepted this cycle.
- `req0_op` / `req1_op`  in  3  aluOp code: 0 add, 1 sub, 2 and, 3 or, 4 sll, 5 slt.
- `req0_a`, `req0_b` / `req1_a`, `req1_b`  in  W  operands A and B.
- `resp_valid`  out  1  the response register holds a result.
- `resp_ready`  in  1  the consumer takes the response this cycle.
- `resp_id`  out  1  requester that issued the response.
- `resp_result`  out  W  ALU result.
- `resp_zero`  out  1  result == 0.
- `resp_sign`  out  1  result[31].
- `resp_err`  out  1  the op code was illegal (6 or 7).
- `conflict_cnt`  out  CNT_W  saturating count of cycles in which both requesters were valid.

## Operation
- The response register holds exactly one entry: {valid, id, result, zero, sign, err}.
- `can_accept` = !resp_valid | resp_ready.
- Grant rules:
  - If only one requester is valid, that requester is granted.
  - If both are valid, the requester ≠ `last_grant` is granted.
  - `last_grant` updates only on an accepted transfer.
- `reqN_ready` = can_accept & granted(N). At most one ready is asserted per cycle. Ready never depends on the ungranted requester's op.
- Mux: the granted requester's op, A and B drive `ALU.aluOp`, `ALU.A` and `ALU.B`. If nothing is granted, requester 0's inputs drive the `ALU`, but nothing is captured.
- On accept, the response register captures the `ALU` result, Zero and Sign, sets id = N, err = 0, and sets valid = 1.
- Illegal op (6 or 7):
  - The request is accepted normally.
  - The `ALU` output is ignored.
  - Captured values: result = 0, zero = 1, sign = 0, err = 1.
- Arithmetic, performed by the `ALU` and width 32 throughout:
  - add and sub are modulo 2^32.
  - sll computes B << A using the full 32-bit A; any A ≥ 32 gives 0.
  - slt is a signed compare and gives 1 or 0.
- Response drain:
  - If resp_ready & resp_valid and no new accept occurs, valid goes to 0 next cycle.
  - If a drain and an accept occur in the same cycle, the new entry replaces the old one and valid stays 1.
- While resp_valid & !resp_ready, the response fields are held stable and both readys are 0.
- `conflict_cnt` increments by 1 in every cycle with req0_valid & req1_valid, regardless of acceptance. It saturates at 2^CNT_W − 1.

## Timing
- Reset values (synchronous, applied when Reset = 1 at the edge):
  - resp_valid = 0, resp_id = 0, resp_result = 0, resp_zero = 0, resp_sign = 0, resp_err = 0.
  - conflict_cnt = 0.
  - last_grant = 1, so requester 0 wins the first conflict.
- readys are combinational from the valids, last_grant, resp_valid and resp_ready. While Reset = 1, both readys are forced to 0.
- Latency: a request accepted at edge k appears on resp_* after edge k; resp_valid is high in cycle k+1.
- Throughput: one operation per cycle while resp_ready is held at 1.
- Handshake: a requester must hold valid, op, A and B stable until its ready is seen. Dropping valid before acceptance is allowed, and the request is then simply never granted.
- Reset asserted mid-operation: the pending response is discarded, `last_grant` returns to 1 and the counter clears. No partial transfer survives the reset.
- Fairness: with both requesters continuously valid and resp_ready = 1, grants alternate 0, 1, 0, 1, ...

## Test plan
- Single request: req0 add A=5, B=7 with resp_ready=1 → req0_ready=1 in the same cycle; next cycle resp_valid=1, id=0, result=12, zero=0, sign=0.
- Conflict fairness: both requesters valid for 4 cycles (req0 sub 3−5, req1 or 0xF0|0x0F), resp_ready=1 → ids 0, 1, 0, 1; results 0xFFFFFFFE with sign=1, and 0xFF; conflict_cnt=4.
- Back-pressure: resp_ready=0 after one accept → both readys 0 and the response held for 3 cycles; raise resp_ready → drain and a new accept in the same cycle, with resp_valid staying 1.
- Edge ops:
  - sll A=4, B=1 → 16.
  - sll A=40, B=1 → 0.
  - slt A=0xFFFFFFFF, B=1 → 1.
  - op 7 → result 0, zero=1, err=1.
- Reset mid-stream: pending resp_valid=1, conflict_cnt=9, then Reset for 1 cycle → all outputs 0. The next conflict is granted to req0.
- Saturation: with CNT_W=4, both requesters valid for 20 cycles → conflict_cnt stops at 15.

Source files
------------

// File: rtl/alu_share_arbiter_if.sv
// Request/response bundle between two requesters, one consumer and the
// shared-ALU arbiter. The master side is the requesters plus the response
// consumer. The slave side is the arbiter itself.
interface alu_share_arbiter_if #(
    parameter int W     = 32,
    parameter int CNT_W = 16
) ();
    logic             req0_valid;
    logic             req0_ready;
    logic [2:0]       req0_op;
    logic [W-1:0]     req0_a;
    logic [W-1:0]     req0_b;

    logic             req1_valid;
    logic             req1_ready;
    logic [2:0]       req1_op;
    logic [W-1:0]     req1_a;
    logic [W-1:0]     req1_b;

    logic             resp_valid;
    logic             resp_ready;
    logic             resp_id;
    logic [W-1:0]     resp_result;
    logic             resp_zero;
    logic             resp_sign;
    logic             resp_err;

    logic [CNT_W-1:0] conflict_cnt;

    modport master (
        output req0_valid, req0_op, req0_a, req0_b,
        output req1_valid, req1_op, req1_a, req1_b,
        output resp_ready,
        input  req0_ready, req1_ready,
        input  resp_valid, resp_id, resp_result, resp_zero, resp_sign, resp_err,
        input  conflict_cnt
    );

    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b,
        input  req1_valid, req1_op, req1_a, req1_b,
        input  resp_ready,
        output req0_ready, req1_ready,
        output resp_valid, resp_id, resp_result, resp_zero, resp_sign, resp_err,
        output conflict_cnt
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// Shared-ALU arbiter: two valid/ready requesters take round-robin turns at
// one combinational ALU. Each accepted result lands in a single registered
// response slot, tagged with the id of the requester that issued it.

// Combinational ALU: add, sub, and, or, sll (B << A), signed slt.
module ALU #(
    parameter int W = 32
) (
    input  logic [2:0]   aluOp,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    output logic [W-1:0] Result,
    output logic         Zero,
    output logic         Sign
);
    localparam int SHW = $clog2(W);

    // Compute the result for the selected op and derive its flags.
    always_comb begin
        Result = '0;
        case (aluOp)
            3'd0:    Result = A + B;
            3'd1:    Result = A - B;
            3'd2:    Result = A & B;
            3'd3:    Result = A | B;
            3'd4:    Result = (A >= W) ? '0 : (B << A[SHW-1:0]);
            3'd5:    Result = {{(W-1){1'b0}}, ($signed(A) < $signed(B))};
            default: Result = '0;
        endcase
        Zero = (Result == '0);
        Sign = Result[W-1];
    end
endmodule

module alu_share_arbiter #(
    parameter int W     = 32,
    parameter int CNT_W = 16
) (
    input  logic                CLK,
    input  logic                Reset,
    alu_share_arbiter_if.slave  bus
);
    // Records which requester won the most recent accepted transfer.
    typedef enum logic {
        LAST_REQ0 = 1'b0,
        LAST_REQ1 = 1'b1
    } last_grant_e;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    last_grant_e      lastGrant_q, lastGrant_d;
    logic             respValid_q, respValid_d;
    logic             respId_q, respId_d;
    logic [W-1:0]     respResult_q, respResult_d;
    logic             respZero_q, respZero_d;
    logic             respSign_q, respSign_d;
    logic             respErr_q, respErr_d;
    logic [CNT_W-1:0] conflictCnt_q, conflictCnt_d;

    logic             canAccept;
    logic             grant0;
    logic             grant1;
    logic             ready0;
    logic             ready1;
    logic             accept;
    logic             opIllegal;
    logic [2:0]       aluOp;
    logic [W-1:0]     aluA;
    logic [W-1:0]     aluB;
    logic [W-1:0]     aluResult;
    logic             aluZero;
    logic             aluSign;

    // Round-robin grant and ready. Only the valids, last grant and the
    // response slot matter, so ready never looks at the ungranted op.
    always_comb begin
        canAccept = !respValid_q || bus.resp_ready;
        grant0    = bus.req0_valid && (!bus.req1_valid || (lastGrant_q == LAST_REQ1));
        grant1    = bus.req1_valid && (!bus.req0_valid || (lastGrant_q == LAST_REQ0));
        ready0    = !Reset && canAccept && grant0;
        ready1    = !Reset && canAccept && grant1;
        accept    = ready0 || ready1;
    end

    // Steer the granted requester into the ALU. Requester 0 is the idle default.
    always_comb begin
        aluOp = bus.req0_op;
        aluA  = bus.req0_a;
        aluB  = bus.req0_b;
        if (grant1) begin
            aluOp = bus.req1_op;
            aluA  = bus.req1_a;
            aluB  = bus.req1_b;
        end
        opIllegal = aluOp[2] && aluOp[1];
    end

    ALU #(.W(W)) u_alu (
        .aluOp  (aluOp),
        .A      (aluA),
        .B      (aluB),
        .Result (aluResult),
        .Zero   (aluZero),
        .Sign   (aluSign)
    );

    // Next state of the response slot, the last grant and the conflict counter.
    always_comb begin
        lastGrant_d   = lastGrant_q;
        respValid_d   = respValid_q;
        respId_d      = respId_q;
        respResult_d  = respResult_q;
        respZero_d    = respZero_q;
        respSign_d    = respSign_q;
        respErr_d     = respErr_q;
        conflictCnt_d = conflictCnt_q;

        if (accept) begin
            lastGrant_d = ready1 ? LAST_REQ1 : LAST_REQ0;
            respValid_d = 1'b1;
            respId_d    = ready1;
            if (opIllegal) begin
                respResult_d = '0;
                respZero_d   = 1'b1;
                respSign_d   = 1'b0;
                respErr_d    = 1'b1;
            end else begin
                respResult_d = aluResult;
                respZero_d   = aluZero;
                respSign_d   = aluSign;
                respErr_d    = 1'b0;
            end
        end else if (respValid_q && bus.resp_ready) begin
            respValid_d = 1'b0;
        end

        if (bus.req0_valid && bus.req1_valid && (conflictCnt_q != CNT_MAX)) begin
            conflictCnt_d = conflictCnt_q + 1'b1;
        end
    end

    // State registers with synchronous reset; requester 0 wins the first conflict.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            lastGrant_q   <= LAST_REQ1;
            respValid_q   <= 1'b0;
            respId_q      <= 1'b0;
            respResult_q  <= '0;
            respZero_q    <= 1'b0;
            respSign_q    <= 1'b0;
            respErr_q     <= 1'b0;
            conflictCnt_q <= '0;
        end else begin
            lastGrant_q   <= lastGrant_d;
            respValid_q   <= respValid_d;
            respId_q      <= respId_d;
            respResult_q  <= respResult_d;
            respZero_q    <= respZero_d;
            respSign_q    <= respSign_d;
            respErr_q     <= respErr_d;
            conflictCnt_q <= conflictCnt_d;
        end
    end

    assign bus.req0_ready   = ready0;
    assign bus.req1_ready   = ready1;
    assign bus.resp_valid   = respValid_q;
    assign bus.resp_id      = respId_q;
    assign bus.resp_result  = respResult_q;
    assign bus.resp_zero    = respZero_q;
    assign bus.resp_sign    = respSign_q;
    assign bus.resp_err     = respErr_q;
    assign bus.conflict_cnt = conflictCnt_q;
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter: a 16-bit-counter instance for the
// functional scenarios and a 4-bit-counter instance for saturation.
module tb_alu_share_arbiter;
    logic CLK;
    logic Reset;
    int   checks;
    int   errors;

    alu_share_arbiter_if #(.W(32), .CNT_W(16)) bus ();
    alu_share_arbiter_if #(.W(32), .CNT_W(4))  busS ();

    alu_share_arbiter #(.W(32), .CNT_W(16)) dut (
        .CLK   (CLK),
        .Reset (Reset),
        .bus   (bus)
    );

    alu_share_arbiter #(.W(32), .CNT_W(4)) dutSat (
        .CLK   (CLK),
        .Reset (Reset),
        .bus   (busS)
    );

    // Free-running clock, 10 time-unit period.
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Drive every master-side input of the main instance at once.
    task automatic applyStimulus(input logic v0, input logic [2:0] op0, input logic [31:0] a0,
                                 input logic [31:0] b0, input logic v1, input logic [2:0] op1,
                                 input logic [31:0] a1, input logic [31:0] b1, input logic rr);
        bus.req0_valid = v0;
        bus.req0_op    = op0;
        bus.req0_a     = a0;
        bus.req0_b     = b0;
        bus.req1_valid = v1;
        bus.req1_op    = op1;
        bus.req1_a     = a1;
        bus.req1_b     = b1;
        bus.resp_ready = rr;
    endtask

    // Advance one clock and sample just after the edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // One-cycle reset with idle inputs on both instances.
    task automatic doReset();
        applyStimulus(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        applyStimulus(1'b1, 3'd0, 32'd1, 32'd1, 1'b1, 3'd0, 32'd2, 32'd2, 1'b1);
        tick();
        tick();
        checks++; if (bus.req0_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_ready0 got %0h want 0", bus.req0_ready); end
        checks++; if (bus.req1_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_ready1 got %0h want 0", bus.req1_ready); end
        checks++; if (bus.resp_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got %0h want 0", bus.resp_valid); end
        checks++; if (bus.resp_id !== 1'b0) begin errors++; $display("[TB] FAIL reset_id got %0h want 0", bus.resp_id); end
        checks++; if (bus.resp_result !== 32'd0) begin errors++; $display("[TB] FAIL reset_result got %0h want 0", bus.resp_result); end
        checks++; if ({bus.resp_zero, bus.resp_sign, bus.resp_err} !== 3'b000) begin errors++; $display("[TB] FAIL reset_flags got %0b want 000", {bus.resp_zero, bus.resp_sign, bus.resp_err}); end
        checks++; if (bus.conflict_cnt !== 16'd0) begin errors++; $display("[TB] FAIL reset_cnt got %0d want 0", bus.conflict_cnt); end
        Reset = 1'b0;
        applyStimulus(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
        #1;
    endtask

    task automatic test_single();
        doReset();
        applyStimulus(1'b1, 3'd0, 32'd5, 32'd7, 1'b0, 3'd0, 32'd0, 32'd0, 1'b1);
        #1;
        checks++; if (bus.req0_ready !== 1'b1) begin errors++; $display("[TB] FAIL single_ready0 got %0h want 1", bus.req0_ready); end
        checks++; if (bus.req1_ready !== 1'b0) begin errors++; $display("[TB] FAIL single_ready1 got %0h want 0", bus.req1_ready); end
        tick();
        applyStimulus(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b1);
        checks++; if (bus.resp_valid !== 1'b1) begin errors++; $display("[TB] FAIL single_valid got %0h want 1", bus.resp_valid); end
        checks++; if (bus.resp_id !== 1'b0) begin errors++; $display("[TB] FAIL single_id got %0h want 0", bus.resp_id); end
        checks++; if (bus.resp_result !== 32'd12) begin errors++; $display("[TB] FAIL single_result got %0h want c", bus.resp_result); end
        checks++; if ({bus.resp_zero, bus.resp_sign, bus.resp_err} !== 3'b000) begin errors++; $display("[TB] FAIL single_flags got %0b want 000", {bus.resp_zero, bus.resp_sign, bus.resp_err}); end
        tick();
        checks++; if (bus.resp_valid !== 1'b0) begin errors++; $display("[TB] FAIL single_drain got %0h want 0", bus.resp_valid); end
    endtask

    task automatic test_conflict();
        logic        expId;
        logic [31:0] expResult;
        logic        expSign;
        doReset();
        applyStimulus(1'b1, 3'd1, 32'd3, 32'd5, 1'b1, 3'd3, 32'h0000_00F0, 32'h0000_000F, 1'b1);
        for (int i = 0; i < 4; i++) begin
            #1;
            expId = (i % 2 == 1);
            checks++; if (bus.req0_ready !== !expId) begin errors++; $display("[TB] FAIL conflict_ready0_%0d got %0h want %0h", i, bus.req0_ready, !expId); end
            checks++; if (bus.req1_ready !== expId) begin errors++; $display("[TB] FAIL conflict_ready1_%0d got %0h want %0h", i, bus.req1_ready, expId); end
            tick();
            expResult = expId ? 32'h0000_00FF : 32'hFFFF_FFFE;
            expSign   = !expId;
            checks++; if (bus.resp_id !== expId) begin errors++; $display("[TB] FAIL conflict_id_%0d got %0h want %0h", i, bus.resp_id, expId); end
            checks++; if (bus.resp_result !== expResult) begin errors++; $display("[TB] FAIL conflict_result_%0d got %0h want %0h", i, bus.resp_result, expResult); end
            checks++; if (bus.resp_sign !== expSign) begin errors++; $display("[TB] FAIL conflict_sign_%0d got %0h want %0h", i, bus.resp_sign, expSign); end
        end
        applyStimulus(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b1);
        #1;
        checks++; if (bus.conflict_cnt !== 16'd4) begin errors++; $display("[TB] FAIL conflict_cnt got %0d want 4", bus.conflict_cnt); end
        tick();
    endtask

    task automatic test_back_pressure();
        doReset();
        applyStimulus(1'b1, 3'd0, 32'd1, 32'd2, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
        #1;
        checks++; if (bus.req0_ready !== 1'b1) begin errors++; $display("[TB] FAIL bp_first_ready got %0h want 1", bus.req0_ready); end
        tick();
        applyStimulus(1'b1, 3'd0, 32'd10, 32'd20, 1'b1, 3'd2, 32'h0000_00FF, 32'h0000_000F, 1'b0);
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if ({bus.req0_ready, bus.req1_ready} !== 2'b00) begin errors++; $display("[TB] FAIL bp_hold_ready_%0d got %0b want 00", i, {bus.req0_ready, bus.req1_ready}); end
            checks++; if (bus.resp_valid !== 1'b1) begin errors++; $display("[TB] FAIL bp_hold_valid_%0d got %0h want 1", i, bus.resp_valid); end
            checks++; if (bus.resp_result !== 32'd3) begin errors++; $display("[TB] FAIL bp_hold_result_%0d got %0h want 3", i, bus.resp_result); end
            tick();
        end
        bus.resp_ready = 1'b1;
        #1;
        checks++; if ({bus.req0_ready, bus.req1_ready} !== 2'b01) begin errors++; $display("[TB] FAIL bp_release_ready got %0b want 01", {bus.req0_ready, bus.req1_ready}); end
        tick();
        applyStimulus(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b1);
        checks++; if (bus.resp_valid !== 1'b1) begin errors++; $display("[TB] FAIL bp_replace_valid got %0h want 1", bus.resp_valid); end
        checks++; if (bus.resp_id !== 1'b1) begin errors++; $display("[TB] FAIL bp_replace_id got %0h want 1", bus.resp_id); end
        checks++; if (bus.resp_result !== 32'h0000_000F) begin errors++; $display("[TB] FAIL bp_replace_result got %0h want f", bus.resp_result); end
        tick();
    endtask

    task automatic test_edge_ops();
        logic [2:0]  opT [7];
        logic [31:0] aT [7];
        logic [31:0] bT [7];
        logic [31:0] resT [7];
        logic [2:0]  flagT [7];
        opT = '{3'd4, 3'd4, 3'd5, 3'd7, 3'd6, 3'd1, 3'd5};
        aT  = '{32'd4, 32'd40, 32'hFFFF_FFFF, 32'd9, 32'd5, 32'd0, 32'd1};
        bT  = '{32'd1, 32'd1, 32'd1, 32'd9, 32'd5, 32'd1, 32'hFFFF_FFFF};
        resT = '{32'd16, 32'd0, 32'd1, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'd0};
        // flags packed as {zero, sign, err}
        flagT = '{3'b000, 3'b100, 3'b000, 3'b101, 3'b101, 3'b010, 3'b100};
        doReset();
        for (int i = 0; i < 7; i++) begin
            applyStimulus(1'b0, 3'd0, 32'd0, 32'd0, 1'b1, opT[i], aT[i], bT[i], 1'b1);
            #1;
            checks++; if (bus.req1_ready !== 1'b1) begin errors++; $display("[TB] FAIL edge_ready_%0d got %0h want 1", i, bus.req1_ready); end
            tick();
            checks++; if (bus.resp_result !== resT[i]) begin errors++; $display("[TB] FAIL edge_result_%0d got %0h want %0h", i, bus.resp_result, resT[i]); end
            checks++; if ({bus.resp_zero, bus.resp_sign, bus.resp_err} !== flagT[i]) begin errors++; $display("[TB] FAIL edge_flags_%0d got %0b want %0b", i, {bus.resp_zero, bus.resp_sign, bus.resp_err}, flagT[i]); end
            checks++; if (bus.resp_id !== 1'b1) begin errors++; $display("[TB] FAIL edge_id_%0d got %0h want 1", i, bus.resp_id); end
        end
        applyStimulus(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b1);
        tick();
    endtask

    task automatic test_reset_midstream();
        doReset();
        applyStimulus(1'b1, 3'd1, 32'd3, 32'd5, 1'b1, 3'd3, 32'h0000_00F0, 32'h0000_000F, 1'b1);
        repeat (9) tick();
        checks++; if (bus.conflict_cnt !== 16'd9) begin errors++; $display("[TB] FAIL mid_cnt got %0d want 9", bus.conflict_cnt); end
        checks++; if (bus.resp_valid !== 1'b1) begin errors++; $display("[TB] FAIL mid_pending got %0h want 1", bus.resp_valid); end
        Reset = 1'b1;
        #1;
        checks++; if ({bus.req0_ready, bus.req1_ready} !== 2'b00) begin errors++; $display("[TB] FAIL mid_reset_ready got %0b want 00", {bus.req0_ready, bus.req1_ready}); end
        tick();
        checks++; if ({bus.resp_valid, bus.resp_id, bus.resp_zero, bus.resp_sign, bus.resp_err} !== 5'b00000) begin errors++; $display("[TB] FAIL mid_reset_resp got %0b want 00000", {bus.resp_valid, bus.resp_id, bus.resp_zero, bus.resp_sign, bus.resp_err}); end
        checks++; if (bus.resp_result !== 32'd0) begin errors++; $display("[TB] FAIL mid_reset_result got %0h want 0", bus.resp_result); end
        checks++; if (bus.conflict_cnt !== 16'd0) begin errors++; $display("[TB] FAIL mid_reset_cnt got %0d want 0", bus.conflict_cnt); end
        Reset = 1'b0;
        #1;
        checks++; if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin errors++; $display("[TB] FAIL mid_regrant got %0b want 10", {bus.req0_ready, bus.req1_ready}); end
        tick();
        applyStimulus(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b1);
        checks++; if (bus.resp_id !== 1'b0) begin errors++; $display("[TB] FAIL mid_regrant_id got %0h want 0", bus.resp_id); end
        checks++; if (bus.resp_result !== 32'hFFFF_FFFE) begin errors++; $display("[TB] FAIL mid_regrant_result got %0h want fffffffe", bus.resp_result); end
        tick();
    endtask

    task automatic test_saturation();
        doReset();
        busS.req0_valid = 1'b1;
        busS.req1_valid = 1'b1;
        busS.resp_ready = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (i == 14) begin
                checks++; if (busS.conflict_cnt !== 4'd14) begin errors++; $display("[TB] FAIL sat_cnt14 got %0d want 14", busS.conflict_cnt); end
            end
        end
        checks++; if (busS.conflict_cnt !== 4'd15) begin errors++; $display("[TB] FAIL sat_cnt20 got %0d want 15", busS.conflict_cnt); end
        busS.req0_valid = 1'b0;
        busS.req1_valid = 1'b0;
    endtask

    // Run every scenario in order, then print the summary.
    initial begin
        checks = 0;
        errors = 0;
        Reset  = 1'b1;
        applyStimulus(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
        busS.req0_valid = 1'b0;
        busS.req0_op    = 3'd0;
        busS.req0_a     = 32'd0;
        busS.req0_b     = 32'd0;
        busS.req1_valid = 1'b0;
        busS.req1_op    = 3'd0;
        busS.req1_a     = 32'd0;
        busS.req1_b     = 32'd0;
        busS.resp_ready = 1'b0;
        test_reset();
        test_single();
        test_conflict();
        test_back_pressure();
        test_edge_ops();
        test_reset_midstream();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
